laser_pulse_checker: RTL and testbench
======================================

# laser_pulse_checker

Receive-side companion to the laser timer state machine: watches the laser photodetector line, measures the width of each laser-on pulse in clock cycles, and classifies it against the expected on-time. Results go to the lab test fixture and status LEDs. Every completed pulse produces a one-cycle report strobe, a good/short/long verdict and a running count of good pulses.

## Interface
- ExpWidth, 16, expected pulse width in Clk cycles
- Tol, 1, allowed deviation (±) from ExpWidth, in cycles
- CntW, 8, width of the internal width counter and the Width output
- Constraints: Tol < ExpWidth; ExpWidth + Tol < 2^CntW − 1

- Clk  input  1  system clock, all logic on rising edge
- Rst  input  1  reset, synchronous, active-high
- D  input  1  photodetector level, asynchronous to Clk, 1 = light present
- Busy  output  1  high while a pulse is being measured
- Done  output  1  one-cycle strobe, a pulse report is valid
- Width  output  CntW  measured width of the last completed pulse
- Good  output  1  last pulse within ExpWidth ± Tol
- Short  output  1  last pulse width < ExpWidth − Tol
- Long  output  1  last pulse width > ExpWidth + Tol, including saturated
- Stuck  output  1  high while measuring with the counter saturated
- GoodCount  output  8  number of Good pulses since reset, wraps 255 → 0

## Operation
- D passes through a 2-flop synchronizer (S1, S2). The FSM sees only S2 (Ds). Synchronizer flops reset to 0.
- States: SArm, SIdle, SMeas.
  - SArm: entered on reset. Waits for Ds == 0, then goes to SIdle. Light already present at reset is never measured.
  - SIdle: when Ds == 1, load Count = 1, set Busy, go to SMeas.
  - SMeas: when Ds == 1, Count <= Count + 1, saturating at 2^CntW − 1. When Ds == 0, register Width = Count, set the class flags, pulse Done, increment GoodCount if Good, clear Busy, go to SIdle.
  - Illegal state: go to SArm with all outputs at reset values.
- Exactly one of Good/Short/Long is set after the first report. All three are 0 before the first report.
- Width, Good, Short and Long hold until the next report. Done is high for exactly one cycle per pulse.
- Stuck = 1 while in SMeas with Count saturated. It clears when the report is generated.
- Comparisons are unsigned, on CntW-bit values. Bounds ExpWidth − Tol and ExpWidth + Tol are inclusive for Good.
- Reset values: Busy 0, Done 0, Width 0, Good 0, Short 0, Long 0, Stuck 0, GoodCount 0, state SArm.

## Timing
- D held high for N consecutive sampled edges (N ≥ 1) yields Width = N; the synchronizer delays both edges equally.
- Busy rises 3 edges after the first edge that samples D = 1.
- Done rises 3 edges after the first edge that samples D = 0, and lasts one cycle.
- Width, the class flags and GoodCount update on the same edge as Done rises.
- Minimum low gap between pulses is 1 sampled cycle. A new pulse is accepted from SIdle on the cycle after Done.
- Rst asserted mid-pulse aborts it: no Done, GoodCount unchanged, state SArm. If D is still high at reset release, the remainder of that pulse is ignored until D goes low.
- GoodCount wrap: the 256th Good pulse yields 0. No flag is raised.
- A 1-cycle glitch on D that survives synchronization is reported as Width = 1 (Short). No filtering is applied.

## Test plan
- Reset, then D high 16 cycles, then low → one Done, Width = 16, Good = 1, Short = Long = 0, GoodCount = 1, Busy high for 16 cycles.
- Pulses of width 14, 15, 17, 18 (defaults) → Short; Good; Good; Long, with Width matching each. GoodCount increments only for 15 and 17.
- D held high 300 cycles (CntW = 8) → Stuck rises after 255 counted cycles, Width = 255, Long = 1, Done once, Stuck clears on Done.
- D high at reset release for 10 cycles, then low, then one 16-cycle pulse → no report for the first pulse; one Good report for the second.
- Rst asserted on the 8th cycle of a pulse → no Done, all outputs at reset values, next full 16-cycle pulse reports Good with GoodCount = 1.
- 256 back-to-back 16-cycle pulses with 1-cycle gaps → 256 Done strobes, GoodCount wraps to 0, no pulse lost.

Source files
------------

// File: rtl/laser_pulse_checker.sv
// rtl/laser_pulse_checker.sv - photodetector pulse width measurement and good/short/long classification
//
// Purpose: synchronizes the photodetector line, measures each laser-on pulse
// in Clk cycles and classifies it against ExpWidth +/- Tol.
//
// Ports:
//   Clk       in   system clock, rising edge
//   Rst       in   synchronous active-high reset
//   D         in   photodetector level (asynchronous), 1 = light
//   Busy      out  high while a pulse is being measured
//   Done      out  one-cycle strobe, report outputs are valid
//   Width     out  width of last completed pulse (CntW bits)
//   Good      out  last pulse within ExpWidth +/- Tol (inclusive)
//   Short     out  last pulse shorter than ExpWidth - Tol
//   Long      out  last pulse longer than ExpWidth + Tol (incl. saturated)
//   Stuck     out  high while measuring with the counter saturated
//   GoodCount out  Good pulses since reset, wraps 255 -> 0
module laser_pulse_checker #(
  parameter int ExpWidth = 16,
  parameter int Tol      = 1,
  parameter int CntW     = 8
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            D,
  output logic            Busy,
  output logic            Done,
  output logic [CntW-1:0] Width,
  output logic            Good,
  output logic            Short,
  output logic            Long,
  output logic            Stuck,
  output logic [7:0]      GoodCount
);

  localparam logic [CntW-1:0] LoBound = CntW'(ExpWidth - Tol);
  localparam logic [CntW-1:0] HiBound = CntW'(ExpWidth + Tol);
  localparam logic [CntW-1:0] CntMax  = '1;

  typedef enum logic [1:0] {
    SArm  = 2'd0,
    SIdle = 2'd1,
    SMeas = 2'd2
  } state_t;

  state_t          state_q;
  logic            s1_q, s2_q;
  // Marks the synchronizer as holding real samples: right after reset S2 still
  // shows its reset value, and arming on that would measure light that was
  // already present at reset release.
  logic [1:0]      fill_q;
  logic [CntW-1:0] count_q;
  logic [CntW-1:0] count_d;
  logic            busy_q, done_q, good_q, short_q, long_q, stuck_q;
  logic [CntW-1:0] width_q;
  logic [7:0]      good_count_q;
  logic            is_short, is_long;

  always_comb begin
    count_d  = (count_q == CntMax) ? count_q : count_q + 1'b1;
    is_short = (count_q < LoBound);
    is_long  = (count_q > HiBound);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= SArm;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      fill_q       <= 2'b00;
      count_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      width_q      <= '0;
      good_q       <= 1'b0;
      short_q      <= 1'b0;
      long_q       <= 1'b0;
      stuck_q      <= 1'b0;
      good_count_q <= 8'd0;
    end else begin
      s1_q   <= D;
      s2_q   <= s1_q;
      fill_q <= {fill_q[0], 1'b1};
      done_q <= 1'b0;
      case (state_q)
        SArm: begin
          if (fill_q[1] && !s2_q) state_q <= SIdle;
        end
        SIdle: begin
          if (s2_q) begin
            count_q <= {{(CntW-1){1'b0}}, 1'b1};
            busy_q  <= 1'b1;
            state_q <= SMeas;
          end
        end
        SMeas: begin
          if (s2_q) begin
            count_q <= count_d;
            stuck_q <= (count_d == CntMax);
          end else begin
            width_q <= count_q;
            short_q <= is_short;
            long_q  <= is_long;
            good_q  <= !is_short && !is_long;
            if (!is_short && !is_long) good_count_q <= good_count_q + 8'd1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            stuck_q <= 1'b0;
            state_q <= SIdle;
          end
        end
        default: begin
          // Unreachable encoding: recover to the reset condition.
          state_q      <= SArm;
          s1_q         <= 1'b0;
          s2_q         <= 1'b0;
          fill_q       <= 2'b00;
          count_q      <= '0;
          busy_q       <= 1'b0;
          done_q       <= 1'b0;
          width_q      <= '0;
          good_q       <= 1'b0;
          short_q      <= 1'b0;
          long_q       <= 1'b0;
          stuck_q      <= 1'b0;
          good_count_q <= 8'd0;
        end
      endcase
    end
  end

  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Width     = width_q;
  assign Good      = good_q;
  assign Short     = short_q;
  assign Long      = long_q;
  assign Stuck     = stuck_q;
  assign GoodCount = good_count_q;

endmodule

// File: tb/tb_laser_pulse_checker.sv
// tb/tb_laser_pulse_checker.sv - directed self-checking bench for laser_pulse_checker
module tb_laser_pulse_checker;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       D;
  logic       Busy, Done, Good, Short, Long, Stuck;
  logic [7:0] Width;
  logic [7:0] GoodCount;

  laser_pulse_checker #(.ExpWidth(16), .Tol(1), .CntW(8)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .D         (D),
    .Busy      (Busy),
    .Done      (Done),
    .Width     (Width),
    .Good      (Good),
    .Short     (Short),
    .Long      (Long),
    .Stuck     (Stuck),
    .GoodCount (GoodCount)
  );

  always #5 Clk = ~Clk;

  int   errors = 0;
  int   checks = 0;
  int   done_cnt, busy_cyc, stuck_cyc, good_rep, done_dbl;
  logic prev_done;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    done_cnt  = 0;
    busy_cyc  = 0;
    stuck_cyc = 0;
    good_rep  = 0;
    done_dbl  = 0;
    prev_done = 1'b0;
  endtask

  // One clock; outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
    if (Done) begin
      done_cnt++;
      if (Good) good_rep++;
      if (prev_done) done_dbl++;
    end
    prev_done = Done;
    if (Busy)  busy_cyc++;
    if (Stuck) stuck_cyc++;
  endtask

  task automatic do_reset(input logic dlev);
    Rst = 1'b1;
    D   = dlev;
    repeat (3) tick();
    Rst = 1'b0;
    clear_stats();
  endtask

  // D high for n sampled edges, then low for gap sampled edges.
  task automatic pulse(input int n, input int gap);
    D = 1'b1;
    repeat (n) tick();
    D = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic check_report(input string tag, input int w, input int g, input int s,
                              input int l, input int gc);
    check({tag, "_width"}, int'(Width), w);
    check({tag, "_good"},  int'(Good),  g);
    check({tag, "_short"}, int'(Short), s);
    check({tag, "_long"},  int'(Long),  l);
    check({tag, "_gcount"}, int'(GoodCount), gc);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  int'(Busy),  0);
    check({tag, "_done"},  int'(Done),  0);
    check({tag, "_stuck"}, int'(Stuck), 0);
    check_report(tag, 0, 0, 0, 0, 0);
  endtask

  int widths [4] = '{14, 15, 17, 18};
  int exp_g  [4] = '{0, 1, 1, 0};
  int exp_s  [4] = '{1, 0, 0, 0};
  int exp_l  [4] = '{0, 0, 0, 1};
  int exp_gc [4] = '{1, 2, 3, 3};

  initial begin
    Rst = 1'b1;
    D   = 1'b0;

    // Reset state and a nominal 16-cycle pulse
    do_reset(1'b0);
    repeat (4) tick();
    check_reset_outputs("rst");
    pulse(16, 4);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_busy_cyc", busy_cyc, 16);
    check_report("t1", 16, 1, 0, 0, 1);

    // Tolerance boundaries
    for (int i = 0; i < 4; i++) begin
      clear_stats();
      pulse(widths[i], 4);
      check($sformatf("t2_w%0d_done", widths[i]), done_cnt, 1);
      check_report($sformatf("t2_w%0d", widths[i]), widths[i], exp_g[i], exp_s[i],
                   exp_l[i], exp_gc[i]);
    end

    // Saturation: 300-cycle pulse; Stuck from count 255 until the report
    clear_stats();
    pulse(300, 4);
    check("t3_done_cnt", done_cnt, 1);
    check("t3_stuck_cyc", stuck_cyc, 46);
    check("t3_stuck_after", int'(Stuck), 0);
    check_report("t3", 255, 0, 0, 1, 3);
    check("t3_dbl_done", done_dbl, 0);

    // Light present at reset release is never measured
    do_reset(1'b1);
    repeat (10) tick();
    D = 1'b0;
    repeat (4) tick();
    check("t4_first_ignored", done_cnt, 0);
    pulse(16, 4);
    check("t4_done_cnt", done_cnt, 1);
    check_report("t4", 16, 1, 0, 0, 1);

    // Reset on the 8th cycle of a pulse aborts it
    pulse(16, 4);
    check("t5_pre_gcount", int'(GoodCount), 2);
    clear_stats();
    D = 1'b1;
    repeat (7) tick();
    Rst = 1'b1;
    repeat (2) tick();
    D   = 1'b0;
    check_reset_outputs("t5_abort");
    Rst = 1'b0;
    repeat (5) tick();
    check("t5_no_done", done_cnt, 0);
    pulse(16, 4);
    check("t5_done_cnt", done_cnt, 1);
    check_report("t5", 16, 1, 0, 0, 1);

    // 256 back-to-back pulses with 1-cycle gaps: GoodCount wraps to 0
    do_reset(1'b0);
    repeat (4) tick();
    for (int i = 0; i < 256; i++) pulse(16, 1);
    repeat (4) tick();
    check("t6_done_cnt", done_cnt, 256);
    check("t6_good_rep", good_rep, 256);
    check("t6_dbl_done", done_dbl, 0);
    check_report("t6", 16, 1, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
